btn_gesture_gen: RTL

//  Button-gesture generator: drives a synthetic active-high button waveform that

---
 rtl/btn_gesture_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/btn_gesture_gen.sv
// Button-gesture generator.
// Each accepted command produces one synthetic active-high button waveform
// (1..4 short presses, one long press, or one hold press) followed by a
// settle interval long enough for the downstream decoder to see the release.
// A single 32-bit down-counter times every phase; each phase ends when the
// counter reaches zero.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for a command; cmd_ready high, btn_out low
//  PRESS  | btn_out high for press_len cycles
//  GAP    | btn_out low between presses of a multi-press gesture
//  SETTLE | btn_out low after the last press; done pulses on exit
module btn_gesture_gen #(
    parameter logic [31:0] T_PRESS  = 32'd10_000_000,
    parameter logic [31:0] T_LONG   = 32'd200_000_000,
    parameter logic [31:0] T_HOLD   = 32'd400_000_000,
    parameter logic [31:0] T_GAP    = 32'd10_000_000,
    parameter logic [31:0] T_SETTLE = 32'd33_554_432
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_code,
    output logic       cmd_ready,
    output logic       btn_out,
    output logic       busy,
    output logic       done,
    output logic       cmd_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRESS  = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    // Counter reload values: a phase of N cycles loads N-1 and ends at zero.
    localparam logic [31:0] PRESS_M1  = T_PRESS - 32'd1;
    localparam logic [31:0] LONG_M1   = T_LONG - 32'd1;
    localparam logic [31:0] HOLD_M1   = T_HOLD - 32'd1;
    localparam logic [31:0] GAP_M1    = T_GAP - 32'd1;
    localparam logic [31:0] SETTLE_M1 = T_SETTLE - 32'd1;

    logic [1:0]  state;
    logic [31:0] cnt;
    logic [2:0]  presses_left;
    logic [31:0] press_reload;

    logic        code_legal;
    logic [2:0]  code_presses;
    logic [31:0] code_reload;

    assign cmd_ready = (state == S_IDLE);

    // Decode the command code into press count and per-press reload value.
    always_comb begin
        code_legal   = 1'b0;
        code_presses = 3'd1;
        code_reload  = PRESS_M1;
        case (cmd_code)
            3'd1, 3'd2, 3'd3, 3'd4: begin
                code_legal   = 1'b1;
                code_presses = cmd_code;
                code_reload  = PRESS_M1;
            end
            3'd5: begin
                code_legal   = 1'b1;
                code_presses = 3'd1;
                code_reload  = LONG_M1;
            end
            3'd6: begin
                code_legal   = 1'b1;
                code_presses = 3'd1;
                code_reload  = HOLD_M1;
            end
            default: begin
                code_legal   = 1'b0;
                code_presses = 3'd1;
                code_reload  = PRESS_M1;
            end
        endcase
    end

    // Gesture sequencer: phase state, phase timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            presses_left <= '0;
            press_reload <= '0;
            btn_out      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (code_legal) begin
                            state        <= S_PRESS;
                            busy         <= 1'b1;
                            btn_out      <= 1'b1;
                            presses_left <= code_presses;
                            press_reload <= code_reload;
                            cnt          <= code_reload;
                        end else begin
                            // Illegal codes are consumed so the sender is not stalled.
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_PRESS: begin
                    if (cnt == 32'd0) begin
                        presses_left <= presses_left - 3'd1;
                        btn_out      <= 1'b0;
                        if (presses_left > 3'd1) begin
                            state <= S_GAP;
                            cnt   <= GAP_M1;
                        end else begin
                            state <= S_SETTLE;
                            cnt   <= SETTLE_M1;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 32'd0) begin
                        state   <= S_PRESS;
                        btn_out <= 1'b1;
                        cnt     <= press_reload;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 32'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    btn_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
